// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and arbiter FSM state encoding shared by alu_core and alu_arbiter.
package alu_pkg;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_MUL = 3'b101;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU; arithmetic wraps mod 2^DATA_W, unknown codes yield 0.
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 3
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] result,
   output logic              zero
);
   always_comb begin
      result = ctrl == CTRL_W'(ALU_ADD) ? a + b :
               ctrl == CTRL_W'(ALU_SUB) ? a - b :
               ctrl == CTRL_W'(ALU_AND) ? a & b :
               ctrl == CTRL_W'(ALU_OR)  ? a | b :
               ctrl == CTRL_W'(ALU_MUL) ? a * b : '0;
      zero = result == '0;
   end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbitration of two requesters onto one shared ALU,
// with a registered result held until the consumer accepts it.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_data1_i,
   input  logic [DATA_W-1:0] req0_data2_i,
   input  logic [CTRL_W-1:0] req0_ctrl_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_data1_i,
   input  logic [DATA_W-1:0] req1_data2_i,
   input  logic [CTRL_W-1:0] req1_ctrl_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_data_o,
   output logic              resp_zero_o,
   output logic              resp_id_o,
   output logic              busy_o
);
   state_t            state;
   logic              ptr;
   logic              op_id;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic [CTRL_W-1:0] op_ctrl;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              gnt0;
   logic              gnt1;

   // Pointer only breaks ties; a lone requester wins outright.
   assign gnt0 = state == IDLE && !rst_i && req0_valid_i && (!req1_valid_i || !ptr);
   assign gnt1 = state == IDLE && !rst_i && req1_valid_i && (!req0_valid_i || ptr);
   assign req0_ready_o = gnt0;
   assign req1_ready_o = gnt1;

   alu_core #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_core (
      .a      (op_a),
      .b      (op_b),
      .ctrl   (op_ctrl),
      .result (alu_result),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         ptr          <= 1'b0;
         op_id        <= 1'b0;
         op_a         <= '0;
         op_b         <= '0;
         op_ctrl      <= '0;
         resp_valid_o <= 1'b0;
         resp_data_o  <= '0;
         resp_zero_o  <= 1'b0;
         resp_id_o    <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt0 || gnt1) begin
               op_a    <= gnt1 ? req1_data1_i : req0_data1_i;
               op_b    <= gnt1 ? req1_data2_i : req0_data2_i;
               op_ctrl <= gnt1 ? req1_ctrl_i : req0_ctrl_i;
               op_id   <= gnt1;
               ptr     <= ~gnt1;
               busy_o  <= 1'b1;
               state   <= EXEC;
            end
            EXEC: begin
               resp_data_o  <= alu_result;
               resp_zero_o  <= alu_zero;
               resp_id_o    <= op_id;
               resp_valid_o <= 1'b1;
               state        <= RESP;
            end
            RESP: if (resp_ready_i) begin
               resp_valid_o <= 1'b0;
               busy_o       <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table plus hand-written arbitration, backpressure and reset sequences.
module tb_alu_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        v0, v1, r0, r1;
   logic [31:0] a0, b0, a1, b1;
   logic [2:0]  c0, c1;
   logic        resp_valid, resp_ready, resp_zero, resp_id, busy;
   logic [31:0] resp_data;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      logic        id;
      logic [2:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        z;
   } vec_t;
   vec_t vecs[11];

   alu_arbiter dut (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(v0), .req0_ready_o(r0), .req0_data1_i(a0), .req0_data2_i(b0), .req0_ctrl_i(c0),
      .req1_valid_i(v1), .req1_ready_o(r1), .req1_data1_i(a1), .req1_data2_i(b1), .req1_ctrl_i(c1),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
      .resp_zero_o(resp_zero), .resp_id_o(resp_id), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic id, input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      if (id) begin v1 = v; c1 = c; a1 = a; b1 = b; end
      else begin v0 = v; c0 = c; a0 = a; b0 = b; end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One full transaction from a single requester with the consumer always ready.
   task automatic run_op(input string nm, input logic id, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic z);
      drive(id, 1'b1, c, a, b);
      #1;
      chk({nm, " ready"}, id ? {r1, r0} : {r0, r1}, 2'b10);
      tick();
      drive(id, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      chk({nm, " exec busy/valid"}, {busy, resp_valid, r0, r1}, 4'b1000);
      tick();
      chk({nm, " resp valid"}, resp_valid, 1'b1);
      chk({nm, " data"}, resp_data, exp);
      chk({nm, " zero"}, resp_zero, z);
      chk({nm, " id"}, resp_id, id);
      tick();
      chk({nm, " back idle"}, {resp_valid, busy}, 2'b00);
   endtask

   initial begin
      vecs[0]  = '{1'b0, 3'b001, 32'd5,        32'd7,        32'd12,       1'b0};
      vecs[1]  = '{1'b1, 3'b010, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{1'b0, 3'b111, 32'h1234,     32'h5678,     32'd0,        1'b1};
      vecs[3]  = '{1'b1, 3'b101, 32'h00010000, 32'h00010000, 32'd0,        1'b1};
      vecs[4]  = '{1'b0, 3'b011, 32'hF0,       32'h3C,       32'h30,       1'b0};
      vecs[5]  = '{1'b1, 3'b100, 32'hA000_0000, 32'h5,       32'hA000_0005, 1'b0};
      vecs[6]  = '{1'b0, 3'b101, 32'd3,        32'd5,        32'd15,       1'b0};
      vecs[7]  = '{1'b1, 3'b000, 32'hFFFF,     32'hFFFF,     32'd0,        1'b1};
      vecs[8]  = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0};
      vecs[9]  = '{1'b1, 3'b110, 32'd9,        32'd9,        32'd0,        1'b1};
      vecs[10] = '{1'b0, 3'b011, 32'h0F0F,     32'hF0F0,     32'd0,        1'b1};
      v0 = 1'b1; v1 = 1'b1; c0 = 3'b001; c1 = 3'b001;
      a0 = 32'd1; b0 = 32'd1; a1 = 32'd1; b1 = 32'd1;
      resp_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      chk("reset outputs", {resp_valid, resp_zero, resp_id, busy}, 4'b0000);
      chk("reset data", resp_data, 32'd0);
      chk("reset ready", {r0, r1}, 2'b00);
      rst = 1'b0;
      v0 = 1'b0; v1 = 1'b0;
      #1;
      chk("idle no ready", {r0, r1}, 2'b00);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].z);

      // Both requesters held valid: grants alternate starting from requester 0.
      do_reset();
      drive(1'b0, 1'b1, 3'b010, 32'd9, 32'd9);
      drive(1'b1, 1'b1, 3'b100, 32'hF0, 32'h0F);
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr%0d grant", k), {r0, r1}, k % 2 ? 2'b01 : 2'b10);
         tick();
         chk($sformatf("rr%0d exec ready", k), {r0, r1}, 2'b00);
         tick();
         chk($sformatf("rr%0d valid", k), resp_valid, 1'b1);
         chk($sformatf("rr%0d data", k), resp_data, k % 2 ? 32'hFF : 32'd0);
         chk($sformatf("rr%0d zero", k), resp_zero, k % 2 ? 1'b0 : 1'b1);
         chk($sformatf("rr%0d id", k), resp_id, k[0]);
         tick();
      end
      v0 = 1'b0; v1 = 1'b0;
      #1;

      // Backpressure: response held while requester 1 waits.
      resp_ready = 1'b0;
      drive(1'b0, 1'b1, 3'b001, 32'd5, 32'd7);
      #1;
      chk("bp grant", {r0, r1}, 2'b10);
      tick();
      v0 = 1'b0;
      drive(1'b1, 1'b1, 3'b001, 32'd1, 32'd1);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp%0d hold", k), {resp_valid, busy, resp_zero, resp_id, r0, r1}, 6'b110000);
         chk($sformatf("bp%0d data", k), resp_data, 32'd12);
         if (k < 4) tick();
      end
      resp_ready = 1'b1;
      tick();
      chk("bp released", {resp_valid, busy, r1}, 3'b001);
      v1 = 1'b0;
      #1;

      // Reset during EXEC: operation dropped and pointer back to requester 0.
      run_op("pre", 1'b0, 3'b001, 32'd1, 32'd2, 32'd3, 1'b0);
      drive(1'b0, 1'b1, 3'b001, 32'd4, 32'd4);
      tick();
      v0 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_exec%0d", k), {resp_valid, busy}, 2'b00);
         tick();
      end
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("rst_exec ptr", {r0, r1}, 2'b10);
      v0 = 1'b0; v1 = 1'b0;
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, operand and result width.
REQ-002 Parameter CTRL_W, default 3, ALU control code width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 req0_valid_i  input  1  requester 0 has an operation pending.
REQ-006 req0_ready_o  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_data1_i, req0_data2_i  input  DATA_W each  requester 0 operands.
REQ-008 req0_ctrl_i  input  CTRL_W  requester 0 ALU control code.
REQ-009 req1_valid_i, req1_ready_o, req1_data1_i, req1_data2_i, req1_ctrl_i  same as REQ-005..008, for requester 1.
REQ-010 resp_valid_o  output  1  result available.
REQ-011 resp_ready_i  input  1  consumer accepts result.
REQ-012 resp_data_o  output  DATA_W  ALU result.
REQ-013 resp_zero_o  output  1  result equals zero.
REQ-014 resp_id_o  output  1  requester index that owns the result.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 Three-state FSM shall be used: IDLE, EXEC, RESP.
REQ-017 In IDLE with at least one valid request, the block shall grant exactly one requester, assert its ready_o combinationally in that cycle, latch its operands, ctrl and id, and enter EXEC.
REQ-018 If both requesters are valid in IDLE, the requester named by a 1-bit priority pointer shall win.
REQ-019 After each grant, the priority pointer shall point to the non-granted requester (round-robin).
REQ-020 If only one requester is valid, it shall be granted regardless of pointer; the pointer still updates per REQ-019.
REQ-021 ready_o shall never be asserted outside IDLE, and at most one ready_o shall be high per cycle.
REQ-022 EXEC shall last exactly one cycle: the ALU shall evaluate latched operands, result and zero flag shall be registered, and the FSM shall enter RESP.
REQ-023 ALU codes: 001 add, 010 sub, 011 AND, 100 OR, 101 multiply; any other code yields result 0.
REQ-024 Add, sub and multiply results shall be truncated to the low DATA_W bits (mod 2^DATA_W).
REQ-025 resp_zero_o shall be 1 if and only if the registered result equals 0, including the illegal-code case.
REQ-026 In RESP, resp_valid_o shall be 1, and resp_data_o, resp_zero_o and resp_id_o shall remain stable until resp_ready_i is sampled high.
REQ-027 When resp_valid_o and resp_ready_i are both high, the FSM shall return to IDLE; a new grant is possible no earlier than the following cycle.
REQ-028 Latency shall be: grant at cycle N, resp_valid_o first high at N+2; minimum issue interval 3 cycles.
REQ-029 Requesters shall hold valid and operands until ready; the block shall not depend on inputs outside the grant cycle.

Reset
REQ-030 While rst_i is high at a clock edge: FSM goes to IDLE; pointer goes to 0 (requester 0 first); resp_valid_o, resp_data_o, resp_zero_o, resp_id_o and busy_o go to 0.
REQ-031 During reset, req0_ready_o and req1_ready_o shall be 0.
REQ-032 Reset asserted in EXEC or RESP shall discard the in-flight operation, and no response for it shall be issued.

Structure
REQ-033 ALU control codes and FSM state encoding shall reside in a shared package alu_pkg.
REQ-034 The datapath shall be a single combinational sub-module alu_core implementing REQ-023..025 (result and zero), instantiated once.

Verification
REQ-035 Reset: rst_i high 2 cycles -> all outputs 0, busy_o 0, no ready_o asserted.
REQ-036 req0 add 5+7 at cycle N -> req0_ready_o at N; at N+2 resp_valid_o=1, data 12, zero 0, id 0.
REQ-037 Both valid after reset: req0 sub 9-9, req1 OR 0xF0|0x0F -> first response data 0, zero 1, id 0; second response data 0xFF, id 1; with both held valid, grants alternate 0,1,0,1.
REQ-038 Backpressure: resp_ready_i low 4 cycles in RESP -> resp outputs unchanged, both ready_o 0, busy_o 1; accept on 5th cycle, then IDLE.
REQ-039 Edge codes: ctrl 111 with any operands -> data 0, zero 1; multiply 0x00010000*0x00010000 -> data 0, zero 1; sub 0-1 -> 0xFFFFFFFF, zero 0.
REQ-040 rst_i pulsed in EXEC -> resp_valid_o never asserts for that operation, and the pointer returns to 0.
